series_arbiter: RTL and testbench

SERIES_ARBITER -- requirements
Module: series_arbiter

---
 rtl/series_arbiter.sv | 175 +++++++++++++++++
 tb/tb_series_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/series_arbiter.sv
// series_arbiter: round-robin arbiter that lets N requesters share a single
// series datapath controller. It grants one requester at a time, issues a
// start pulse, waits for the datapath to go busy and come back, then returns
// the result with a one-cycle done pulse. A datapath that never goes busy
// ends the transaction after TMO cycles with err set.
module series_arbiter #(
    parameter int N   = 4,
    parameter int W   = 16,
    parameter int TMO = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] x_in,
    input  logic           dp_ready,
    input  logic [W-1:0]   dp_result,
    output logic           dp_start,
    output logic [W-1:0]   dp_x,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic [W-1:0]   res,
    output logic           err
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (TMO > 1) ? $clog2(TMO + 1) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        DELIVER   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [N-1:0]    done_q, done_d;
    logic            dp_start_q, dp_start_d;
    logic            err_q, err_d;
    logic [W-1:0]    dp_x_q, dp_x_d;
    logic [W-1:0]    res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tmo_q, tmo_d;
    logic [LW-1:0]   last_q, last_d;

    logic            found;
    logic [LW-1:0]   win;
    logic [LW-1:0]   cand_idx;
    logic [W-1:0]    win_x;
    int              cand;

    // Round-robin search: first request after the last winner, wrapping around.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= N; i++) begin
            cand     = (int'(last_q) + i) % N;
            cand_idx = LW'(cand);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                win   = cand_idx;
            end
        end
    end

    // Select the winner's operand slice from the packed operand bus.
    always_comb begin
        win_x = '0;
        for (int k = 0; k < N; k++) begin
            if (LW'(k) == win) begin
                win_x = x_in[k*W +: W];
            end
        end
    end

    // Next-state and next-output logic; all outputs are registered from here.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        dp_start_d = 1'b0;
        err_d      = 1'b0;
        dp_x_d     = dp_x_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        last_d     = last_q;
        case (state_q)
            IDLE: begin
                if (dp_ready && found) begin
                    state_d    = GRANT;
                    gnt_d      = N'(1) << win;
                    dp_x_d     = win_x;
                    last_d     = win;
                    dp_start_d = 1'b1;
                end
            end
            GRANT: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!dp_ready) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(TMO)) begin
                        state_d = DELIVER;
                        tmo_d   = 1'b1;
                        done_d  = gnt_q;
                        res_d   = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                if (dp_ready) begin
                    state_d = DELIVER;
                    done_d  = gnt_q;
                    res_d   = dp_result;
                    err_d   = tmo_q;
                end
            end
            DELIVER: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
                tmo_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
                tmo_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            dp_start_q <= 1'b0;
            err_q      <= 1'b0;
            dp_x_q     <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
            last_q     <= LW'(N - 1);
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            dp_start_q <= dp_start_d;
            err_q      <= err_d;
            dp_x_q     <= dp_x_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            last_q     <= last_d;
        end
    end

    assign dp_start = dp_start_q;
    assign dp_x     = dp_x_q;
    assign gnt      = gnt_q;
    assign done     = done_q;
    assign res      = res_q;
    assign err      = err_q;

endmodule

// File: tb/tb_series_arbiter.sv
// tb_series_arbiter: scoreboard bench for series_arbiter. Each batch of
// requests pushes its expected transactions (round-robin order, operand,
// result, error flag) into a queue; a monitor pops and compares whenever
// dp_start or done appears. A behavioural datapath model answers dp_start.
module tb_series_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TMO = 4;

    typedef struct {
        int           idx;
        logic [W-1:0] x;
        logic [W-1:0] res;
        logic         err;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] x_in = '0;
    logic           dp_ready = 1'b1;
    logic [W-1:0]   dp_result = '0;
    logic           dp_start;
    logic [W-1:0]   dp_x;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [W-1:0]   res;
    logic           err;

    exp_t           sb[$];
    int             n_checks = 0;
    int             n_fail = 0;
    int             last_model = N - 1;
    bit             tmo_mode = 1'b0;
    bit             scramble_en = 1'b0;
    int             force_lat = 0;
    int             dp_lat = 0;
    int             cycle = 0;
    int             start_cycle = 0;
    logic [N-1:0]   touched = '0;

    series_arbiter #(.N(N), .W(W), .TMO(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .x_in      (x_in),
        .dp_ready  (dp_ready),
        .dp_result (dp_result),
        .dp_start  (dp_start),
        .dp_x      (dp_x),
        .gnt       (gnt),
        .done      (done),
        .res       (res),
        .err       (err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [W-1:0] series_fn(input logic [W-1:0] x);
        return x * 16'd3 + 16'h1234;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    task automatic reportTimeout(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cycle);
    endtask

    // Raise a batch of requests and queue the order the arbiter must serve them in.
    task automatic applyStimulus(input logic [N-1:0] mask, input bit use_fixed, input logic [W-1:0] fixed_x);
        exp_t e;
        int   base;
        int   new_last;
        touched = '0;
        for (int k = 0; k < N; k++) begin
            if (mask[k]) x_in[k*W +: W] = use_fixed ? fixed_x : W'($urandom);
        end
        req = mask;
        base = last_model;
        new_last = last_model;
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (base + i) % N;
            if (mask[k]) begin
                e.idx = k;
                e.x   = x_in[k*W +: W];
                e.err = tmo_mode;
                e.res = tmo_mode ? '0 : series_fn(e.x);
                sb.push_back(e);
                new_last = k;
            end
        end
        last_model = new_last;
    endtask

    // Requester behaviour: drop on done; once granted, maybe disturb operand or drop early.
    task automatic agentStep();
        for (int k = 0; k < N; k++) begin
            if (done[k]) begin
                req[k] = 1'b0;
            end else if (scramble_en && gnt[k] && !touched[k]) begin
                touched[k] = 1'b1;
                if ($urandom_range(0, 1) == 1) x_in[k*W +: W] = W'($urandom);
                if ($urandom_range(0, 1) == 1) req[k] = 1'b0;
            end
        end
    endtask

    task automatic waitDrain(input string name);
        bit drained;
        drained = 1'b0;
        for (int c = 0; c < 400 && !drained; c++) begin
            @(negedge clk);
            agentStep();
            if (sb.size() == 0) drained = 1'b1;
        end
        if (!drained) begin
            reportTimeout(name);
            sb.delete();
        end
        repeat (2) begin
            @(negedge clk);
            agentStep();
        end
    endtask

    // Datapath model: goes busy after dp_start for a random time, or never in timeout mode.
    initial begin
        int           lat;
        logic [W-1:0] xs;
        forever begin
            @(negedge clk);
            if (dp_start) begin
                if (tmo_mode) begin
                    dp_result = W'($urandom);
                    dp_lat = 0;
                end else begin
                    lat = (force_lat != 0) ? force_lat : int'($urandom_range(2, 10));
                    dp_lat = lat;
                    xs = dp_x;
                    dp_ready = 1'b0;
                    dp_result = W'($urandom);
                    repeat (lat) @(negedge clk);
                    dp_result = series_fn(xs);
                    dp_ready = 1'b1;
                end
            end
        end
    end

    // Monitor: compares DUT activity against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cycle++;
            if (gnt != '0) checkOutput("gnt_onehot", 32'($countones(gnt)), 32'd1);
            if (dp_start) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_start", 32'(gnt), 32'd0);
                end else begin
                    checkOutput("start_gnt", 32'(gnt), 32'(1) << sb[0].idx);
                    checkOutput("start_dp_x", 32'(dp_x), 32'(sb[0].x));
                    start_cycle = cycle;
                end
            end
            if (done != '0) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("done_idx", 32'(done), 32'(1) << e.idx);
                    checkOutput("done_gnt", 32'(gnt), 32'(1) << e.idx);
                    checkOutput("done_dp_x", 32'(dp_x), 32'(e.x));
                    checkOutput("done_res", 32'(res), 32'(e.res));
                    checkOutput("done_err", 32'(err), 32'(e.err));
                    checkOutput("done_latency", 32'(cycle - start_cycle),
                                e.err ? 32'(TMO + 1) : 32'(dp_lat + 1));
                end
            end
        end
    end

    // Global bound so the bench can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence: reset, directed scenarios, then randomized batches.
    initial begin
        bit seen;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_dp_start", 32'(dp_start), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_dp_x", 32'(dp_x), 32'd0);
        checkOutput("rst_res", 32'(res), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] single request");
        force_lat = 10;
        applyStimulus(4'b0001, 1'b1, 16'h0003);
        @(negedge clk);
        checkOutput("first_start", 32'(dp_start), 32'd1);
        checkOutput("first_gnt", 32'(gnt), 32'd1);
        checkOutput("first_dp_x", 32'(dp_x), 32'h3);
        waitDrain("single_drain");
        force_lat = 0;

        $display("[TB] all requesting");
        scramble_en = 1'b1;
        repeat (2) begin
            applyStimulus(4'b1111, 1'b0, '0);
            waitDrain("all_drain");
        end

        $display("[TB] priority wrap");
        applyStimulus(4'b0100, 1'b0, '0);
        waitDrain("wrap_pre_drain");
        applyStimulus(4'b1011, 1'b0, '0);
        waitDrain("wrap_drain");

        $display("[TB] timeout");
        tmo_mode = 1'b1;
        applyStimulus(4'b0110, 1'b0, '0);
        waitDrain("tmo_drain");
        tmo_mode = 1'b0;

        $display("[TB] reset mid-run");
        force_lat = 12;
        applyStimulus(4'b0001, 1'b0, '0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (dp_start) seen = 1'b1;
        end
        if (!seen) reportTimeout("mid_reset_start");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        req = '0;
        sb.delete();
        @(negedge clk);
        checkOutput("mid_rst_gnt", 32'(gnt), 32'd0);
        checkOutput("mid_rst_done", 32'(done), 32'd0);
        checkOutput("mid_rst_dp_start", 32'(dp_start), 32'd0);
        checkOutput("mid_rst_err", 32'(err), 32'd0);
        checkOutput("mid_rst_dp_x", 32'(dp_x), 32'd0);
        checkOutput("mid_rst_res", 32'(res), 32'd0);
        rst = 1'b1;
        last_model = N - 1;
        force_lat = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (dp_ready) seen = 1'b1;
        end
        if (!seen) reportTimeout("mid_reset_dp_idle");
        applyStimulus(4'b0010, 1'b0, '0);
        waitDrain("post_reset_drain");

        $display("[TB] random batches");
        repeat (25) begin
            tmo_mode = ($urandom_range(0, 3) == 0);
            applyStimulus(N'($urandom_range(1, (1 << N) - 1)), 1'b0, '0);
            waitDrain("random_drain");
        end
        tmo_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
